dual_axis_step_sequencer: RTL and testbench

//  Sits between ScaraController and the two joint driver pins. Accepts one move (steps1/steps2 + dirs),

---
 rtl/scara_motion_pkg.sv | 14 +
 rtl/step_pulse_timer.sv | 28 ++
 rtl/dual_axis_step_sequencer.sv | 174 +++++++++++++++++
 tb/tb_dual_axis_step_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scara_motion_pkg.sv
// Shared types and widths for the SCARA joint step sequencer.
package scara_motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HI,
    LO
  } seq_state_t;

  localparam int STEP_CNT_W = 8;
  localparam int ERR_W      = 10;

endpackage

// File: rtl/step_pulse_timer.sv
// Loadable down-counter that paces the sequencer's phases; expire is high on the
// last enabled cycle of a loaded interval (load value N-1 gives an N-cycle phase).
module step_pulse_timer #(
  parameter int TIMER_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               enable,
  output logic               expire
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = enable && (count_reg == '0);

endmodule

// File: rtl/dual_axis_step_sequencer.sv
// Two-joint STEP/DIR generator with Bresenham interpolation so both joints finish together.
// Define STEP_RAMP_EN to make the major-axis period start at RAMP_START_CYC and shrink per step.
module dual_axis_step_sequencer
  import scara_motion_pkg::*;
#(
  parameter int PULSE_CYC      = 100,
  parameter int PERIOD_CYC     = 50000,
  parameter int DIR_SETUP_CYC  = 250,
  parameter int TIMER_W        = 20,
  parameter int RAMP_START_CYC = 200000,
  parameter int RAMP_DEC_CYC   = 5000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       new_in,
  input  logic [7:0] steps1,
  input  logic [7:0] steps2,
  input  logic       dir1_in,
  input  logic       dir2_in,
  input  logic       enable,
  output logic       ready,
  output logic       done,
  output logic       step1,
  output logic       step2,
  output logic       dir1,
  output logic       dir2,
  output logic [7:0] steps_done
);

`ifdef STEP_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  localparam logic [TIMER_W-1:0] SETUP_LOAD   = TIMER_W'(DIR_SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] HI_LOAD      = TIMER_W'(PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] PULSE_PLUS1  = TIMER_W'(PULSE_CYC + 1);
  localparam logic [TIMER_W-1:0] PERIOD_MIN   = TIMER_W'(PERIOD_CYC);
  localparam logic [TIMER_W-1:0] PERIOD_FIRST = RAMP_ON ? TIMER_W'(RAMP_START_CYC) : PERIOD_MIN;
  localparam logic [TIMER_W-1:0] PERIOD_DEC   = RAMP_ON ? TIMER_W'(RAMP_DEC_CYC) : '0;

  seq_state_t state_reg, state_next;
  logic [STEP_CNT_W-1:0] major_reg, minor_reg, steps_done_reg;
  logic [STEP_CNT_W-1:0] major_in, minor_in;
  logic signed [ERR_W-1:0] err_reg, err_dec, err_next, minor_ext, major_ext;
  logic [TIMER_W-1:0] period_reg, timer_val;
  logic major1_reg, major1_in, fire_reg, fire;
  logic dir1_reg, dir2_reg, done_reg, done_next;
  logic accept, move_zero, timer_load, expire, enter_hi, ramp_step, pulse_on;

  assign major1_in = (steps1 >= steps2);
  assign major_in  = major1_in ? steps1 : steps2;
  assign minor_in  = major1_in ? steps2 : steps1;
  assign move_zero = (steps1 == '0) && (steps2 == '0);
  assign accept    = (state_reg == IDLE) && new_in && enable;

  // Error term update applied on every entry to HI; sign bit decides the minor pulse.
  assign minor_ext = $signed({{(ERR_W-STEP_CNT_W){1'b0}}, minor_reg});
  assign major_ext = $signed({{(ERR_W-STEP_CNT_W){1'b0}}, major_reg});
  assign err_dec   = err_reg - minor_ext;
  assign fire      = err_dec[ERR_W-1];
  assign err_next  = fire ? (err_dec + major_ext) : err_dec;

  step_pulse_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk_50),
    .rst      (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .enable   (enable),
    .expire   (expire)
  );

  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    enter_hi   = 1'b0;
    ramp_step  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (move_zero) begin
            done_next = 1'b1;
          end else begin
            state_next = SETUP;
            timer_load = 1'b1;
            timer_val  = SETUP_LOAD;
          end
        end
      end
      SETUP: begin
        if (expire) begin
          state_next = HI;
          timer_load = 1'b1;
          timer_val  = HI_LOAD;
          enter_hi   = 1'b1;
        end
      end
      HI: begin
        if (expire) begin
          state_next = LO;
          timer_load = 1'b1;
          timer_val  = period_reg - PULSE_PLUS1;
        end
      end
      LO: begin
        if (expire) begin
          if (steps_done_reg == major_reg) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = HI;
            timer_load = 1'b1;
            timer_val  = HI_LOAD;
            enter_hi   = 1'b1;
            ramp_step  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      major_reg      <= '0;
      minor_reg      <= '0;
      major1_reg     <= 1'b1;
      err_reg        <= '0;
      fire_reg       <= 1'b0;
      steps_done_reg <= '0;
      dir1_reg       <= 1'b0;
      dir2_reg       <= 1'b0;
      done_reg       <= 1'b0;
      period_reg     <= PERIOD_FIRST;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (accept) begin
        major_reg      <= major_in;
        minor_reg      <= minor_in;
        major1_reg     <= major1_in;
        err_reg        <= $signed({{(ERR_W-STEP_CNT_W+1){1'b0}}, major_in[STEP_CNT_W-1:1]});
        steps_done_reg <= '0;
        dir1_reg       <= dir1_in;
        dir2_reg       <= dir2_in;
        period_reg     <= PERIOD_FIRST;
      end
      if (enter_hi) begin
        steps_done_reg <= steps_done_reg + 1'b1;
        err_reg        <= err_next;
        fire_reg       <= fire;
      end
      // Saturating acceleration: never drop below the cruise period.
      if (ramp_step) begin
        period_reg <= ((period_reg - PERIOD_MIN) >= PERIOD_DEC) ? (period_reg - PERIOD_DEC)
                                                                : PERIOD_MIN;
      end
    end
  end

  assign pulse_on   = (state_reg == HI) && enable;
  assign step1      = pulse_on && (major1_reg || fire_reg);
  assign step2      = pulse_on && (!major1_reg || fire_reg);
  assign ready      = (state_reg == IDLE);
  assign done       = done_reg;
  assign dir1       = dir1_reg;
  assign dir2       = dir2_reg;
  assign steps_done = steps_done_reg;

endmodule

// File: tb/tb_dual_axis_step_sequencer.sv
// Directed bench for dual_axis_step_sequencer: per-cycle comparison against a timeline model
// plus hand-computed expectations for each move.
`timescale 1ns/1ps
module tb_dual_axis_step_sequencer;

  localparam int PULSE  = 2;
  localparam int PERIOD = 10;
  localparam int SETUP  = 3;
  localparam int RSTART = 30;
  localparam int RDEC   = 5;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b0;
  logic       new_in = 1'b0;
  logic [7:0] steps1 = '0;
  logic [7:0] steps2 = '0;
  logic       dir1_in = 1'b0;
  logic       dir2_in = 1'b0;
  logic       enable = 1'b1;
  logic       ready, done, step1, step2, dir1, dir2;
  logic [7:0] steps_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  dual_axis_step_sequencer #(
    .PULSE_CYC(PULSE), .PERIOD_CYC(PERIOD), .DIR_SETUP_CYC(SETUP), .TIMER_W(20),
    .RAMP_START_CYC(RSTART), .RAMP_DEC_CYC(RDEC)
  ) dut (
    .clk_50(clk_50), .reset(reset), .new_in(new_in), .steps1(steps1), .steps2(steps2),
    .dir1_in(dir1_in), .dir2_in(dir2_in), .enable(enable), .ready(ready), .done(done),
    .step1(step1), .step2(step2), .dir1(dir1), .dir2(dir2), .steps_done(steps_done)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc = cyc + 1;

  // ---------------- timeline model ----------------
  // m_o counts enabled clock edges since the accepting edge; step k of the major axis is
  // high while m_s[k] <= m_o < m_s[k]+PULSE.
  bit m_busy, m_done, m_dir1, m_dir2, m_j1;
  int m_o, m_maj, m_min, m_sd_last, m_end;
  int m_s[0:255];

  function automatic int period_of(input int k);
`ifdef STEP_RAMP_EN
    int p;
    p = RSTART - k * RDEC;
    return (p < PERIOD) ? PERIOD : p;
`else
    return PERIOD;
`endif
  endfunction

  // Number of minor pulses issued after n major steps (error starts at major/2).
  function automatic int fires_upto(input int n, input int maj, input int mn);
    if (maj == 0) return 0;
    return (n * mn - maj / 2 + maj - 1) / maj;
  endfunction

  always @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_dir1 = 0; m_dir2 = 0; m_j1 = 1;
      m_o = 0; m_maj = 0; m_min = 0; m_sd_last = 0; m_end = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (enable) begin
          m_o = m_o + 1;
          if (m_o == m_end) begin
            m_busy = 0; m_done = 1; m_sd_last = m_maj;
          end
        end
      end else if (new_in && enable) begin
        m_dir1 = dir1_in; m_dir2 = dir2_in;
        m_j1 = (steps1 >= steps2);
        m_maj = m_j1 ? int'(steps1) : int'(steps2);
        m_min = m_j1 ? int'(steps2) : int'(steps1);
        m_sd_last = 0;
        if (m_maj == 0) begin
          m_done = 1;
        end else begin
          m_busy = 1; m_o = 0; m_s[0] = SETUP;
          for (int k = 1; k <= m_maj && k < 256; k++) m_s[k] = m_s[k-1] + period_of(k-1);
          m_end = (m_maj < 256) ? m_s[m_maj] : 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_50) begin : cmp
    logic [13:0] e_v, a_v;
    bit maj_on, min_on;
    int sd;
    maj_on = 0; min_on = 0;
    sd = m_busy ? 0 : m_sd_last;
    if (m_busy) begin
      for (int k = 0; k < m_maj; k++) begin
        if (m_o >= m_s[k]) sd = k + 1;
        if (m_o >= m_s[k] && m_o < m_s[k] + PULSE && enable) begin
          maj_on = 1;
          min_on = (fires_upto(k + 1, m_maj, m_min) != fires_upto(k, m_maj, m_min));
        end
      end
    end
    e_v = {!m_busy, m_done, (m_j1 ? maj_on : min_on), (m_j1 ? min_on : maj_on),
           m_dir1, m_dir2, sd[7:0]};
    a_v = {ready, done, step1, step2, dir1, dir2, steps_done};
    n_cmp = n_cmp + 1;
    if (a_v !== e_v) begin
      n_bad = n_bad + 1;
      if (n_bad <= 20)
        $display("FAIL cycle %0d outputs: got rdy=%b done=%b step=%b%b dir=%b%b sd=%0d, want rdy=%b done=%b step=%b%b dir=%b%b sd=%0d",
                 cyc, a_v[13], a_v[12], a_v[11], a_v[10], a_v[9], a_v[8], a_v[7:0],
                 e_v[13], e_v[12], e_v[11], e_v[10], e_v[9], e_v[8], e_v[7:0]);
    end
  end

  // ---------------- edge monitor ----------------
  bit p1, p2;
  int n_dn = 0;
  int last_done_cyc = -1;
  int r1_q[$];
  int r2_q[$];

  always @(negedge clk_50) begin
    if (step1 && !p1) r1_q.push_back(cyc);
    if (step2 && !p2) r2_q.push_back(cyc);
    if (done) begin n_dn = n_dn + 1; last_done_cyc = cyc; end
    p1 = step1; p2 = step2;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic start_move(input string tag, input int s1, input int s2, input bit d1,
                            input bit d2, output int t_acc);
    @(posedge clk_50); #2;
    steps1 = 8'(s1); steps2 = 8'(s2); dir1_in = d1; dir2_in = d2; new_in = 1'b1;
    @(posedge clk_50); #2;
    t_acc = cyc;
    new_in = 1'b0;
    $display("%s: steps1=%0d steps2=%0d dir=%b%b accepted at edge %0d", tag, s1, s2, d1, d2, t_acc);
  endtask

  task automatic wait_done(input string tag, input int bd);
    int k;
    k = 0;
    while (n_dn == bd && k < 600) begin @(negedge clk_50); k++; end
    check({tag, " done seen"}, (n_dn > bd) ? 1 : 0, 1);
    repeat (3) @(negedge clk_50);
    check({tag, " done count"}, n_dn - bd, 1);
  endtask

  function automatic int coincident(input int b1, input int b2);
    int c;
    c = 0;
    for (int i = b1; i < r1_q.size(); i++)
      for (int j = b2; j < r2_q.size(); j++)
        if (r1_q[i] == r2_q[j]) c++;
    return c;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int t, b1, b2, bd, mask, gmin, gmax, rdy_ok;
    #1 reset = 1'b1;
    #1;
    check("reset ready", int'(ready), 1);
    check("reset done", int'(done), 0);
    check("reset step1|step2", int'(step1 | step2), 0);
    check("reset dir1|dir2", int'(dir1 | dir2), 0);
    check("reset steps_done", int'(steps_done), 0);
    repeat (3) @(posedge clk_50);
    #2 reset = 1'b0;

    // T1: joint1 major 8, joint2 minor 4
    b1 = r1_q.size(); b2 = r2_q.size(); bd = n_dn;
    start_move("T1", 8, 4, 1'b1, 1'b0, t);
    wait_done("T1", bd);
    check("T1 step1 pulses", r1_q.size() - b1, 8);
    check("T1 step2 pulses", r2_q.size() - b2, 4);
    mask = 0;
    for (int i = 0; i < 8 && b1 + i < r1_q.size(); i++)
      for (int j = b2; j < r2_q.size(); j++)
        if (r2_q[j] == r1_q[b1 + i]) mask = mask | (1 << i);
    check("T1 step2 on major pulses 2,4,6,8", mask, 'haa);
    check("T1 steps_done", int'(steps_done), 8);
    check("T1 dir1", int'(dir1), 1);
    check("T1 dir2", int'(dir2), 0);
    if (r1_q.size() > b1) check("T1 first rise offset", r1_q[b1] - t + 1, 4);
`ifndef STEP_RAMP_EN
    gmin = 1000; gmax = 0;
    for (int i = b1 + 1; i < r1_q.size(); i++) begin
      if (r1_q[i] - r1_q[i-1] < gmin) gmin = r1_q[i] - r1_q[i-1];
      if (r1_q[i] - r1_q[i-1] > gmax) gmax = r1_q[i] - r1_q[i-1];
    end
    check("T1 min step1 gap", gmin, 10);
    check("T1 max step1 gap", gmax, 10);
    check("T1 done offset", last_done_cyc - t, 83);
`endif

    // T2: zero move
    b1 = r1_q.size(); b2 = r2_q.size();
    start_move("T2", 0, 0, 1'b0, 1'b1, t);
    rdy_ok = 1;
    repeat (6) begin
      @(negedge clk_50);
      if (!ready) rdy_ok = 0;
    end
    check("T2 done offset", last_done_cyc - t, 0);
    check("T2 ready held", rdy_ok, 1);
    check("T2 no step edges", (r1_q.size() - b1) + (r2_q.size() - b2), 0);
    check("T2 steps_done", int'(steps_done), 0);

    // T3: joint2 major 7, joint1 minor 3
    b1 = r1_q.size(); b2 = r2_q.size(); bd = n_dn;
    start_move("T3", 3, 7, 1'b0, 1'b1, t);
    wait_done("T3", bd);
    check("T3 step2 pulses", r2_q.size() - b2, 7);
    check("T3 step1 pulses", r1_q.size() - b1, 3);
    if (r2_q.size() > b2) check("T3 first rise offset", r2_q[b2] - t + 1, 4);
    check("T3 steps_done", int'(steps_done), 7);

    // T4: tie 5/5 with a second strobe mid-move
    b1 = r1_q.size(); b2 = r2_q.size(); bd = n_dn;
    start_move("T4", 5, 5, 1'b1, 1'b1, t);
    repeat (20) @(posedge clk_50);
    #2 steps1 = 8'd9; steps2 = 8'd9; new_in = 1'b1;
    @(posedge clk_50);
    #2 new_in = 1'b0;
    $display("T4: ignored strobe steps=9/9 at edge %0d", cyc);
    wait_done("T4", bd);
    check("T4 step1 pulses", r1_q.size() - b1, 5);
    check("T4 step2 pulses", r2_q.size() - b2, 5);
    check("T4 coincident pulses", coincident(b1, b2), 5);
    check("T4 steps_done", int'(steps_done), 5);

    // T5: pause for 20 edges during the HI phase of pulse 3
    b1 = r1_q.size(); b2 = r2_q.size(); bd = n_dn;
    start_move("T5", 6, 3, 1'b0, 1'b0, t);
    while (cyc < t + 24) begin @(posedge clk_50); #2; end
    enable = 1'b0;
    @(negedge clk_50);
    check("T5 step1 low while paused", int'(step1), 0);
    repeat (20) @(posedge clk_50);
    #2 enable = 1'b1;
    $display("T5: paused edges %0d..%0d", t + 25, t + 44);
    wait_done("T5", bd);
    check("T5 steps_done", int'(steps_done), 6);
    check("T5 step2 pulses", r2_q.size() - b2, 3);
`ifndef STEP_RAMP_EN
    if (r1_q.size() > b1) check("T5 last rise offset", r1_q[r1_q.size()-1] - t, 73);
    check("T5 done offset", last_done_cyc - t, 83);
`endif

    // T6: async reset during pulse 4, then a full move
    start_move("T6", 8, 4, 1'b1, 1'b1, t);
    while (cyc < t + 33) begin @(posedge clk_50); #2; end
    reset = 1'b1;
    #1;
    check("T6 step1 after reset", int'(step1), 0);
    check("T6 ready after reset", int'(ready), 1);
    check("T6 steps_done after reset", int'(steps_done), 0);
    check("T6 dir1 after reset", int'(dir1), 0);
    repeat (2) @(posedge clk_50);
    #2 reset = 1'b0;
    b1 = r1_q.size(); b2 = r2_q.size(); bd = n_dn;
    start_move("T6b", 8, 4, 1'b1, 1'b0, t);
    wait_done("T6b", bd);
    check("T6b step1 pulses", r1_q.size() - b1, 8);
    check("T6b step2 pulses", r2_q.size() - b2, 4);
    check("T6b steps_done", int'(steps_done), 8);

`ifdef STEP_RAMP_EN
    // T7: ramped single-axis move
    b1 = r1_q.size(); bd = n_dn;
    start_move("T7", 6, 0, 1'b1, 1'b0, t);
    wait_done("T7", bd);
    check("T7 step1 pulses", r1_q.size() - b1, 6);
    for (int i = 1; i < 6 && b1 + i < r1_q.size(); i++)
      check($sformatf("T7 gap %0d", i), r1_q[b1 + i] - r1_q[b1 + i - 1], 30 - 5 * (i - 1));
`endif

    repeat (3) @(negedge clk_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
